// File: rtl/jpeg_izigzag_buf.sv
// jpeg_izigzag_buf: inverse zigzag reorder buffer for 8x8 coefficient blocks.
// Blocks arrive in zigzag scan order and leave in raster order. Two 64-entry
// banks (ping-pong) let one block fill while the previous one drains.
// Optional macro JPEG_IZIGZAG_TRANSPOSE_EN: drain each block column-major
// (read index k addresses raster (k%8)*8 + k/8). The write path is unchanged.
module jpeg_izigzag_buf #(
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_valid,
  input  logic              din_sof,
  output logic              din_ready,
  output logic [DWIDTH-1:0] dout,
  output logic [5:0]        dout_idx,
  output logic              dout_first,
  output logic              dout_last,
  output logic              dout_valid,
  input  logic              dout_ready
);

  // Zigzag scan position -> raster index (row*8+col), standard JPEG order.
  localparam logic [5:0] ZZ2R [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Bank select is the address MSB; contents are never reset.
  logic [DWIDTH-1:0] mem [0:127];

  logic       wr_bank;
  logic [5:0] wr_idx;
  logic       rd_bank;
  logic [5:0] rd_idx;
  logic [1:0] full;

  logic       wr_acc;
  logic [5:0] wr_pos;
  logic [5:0] wr_raster;
  logic       wr_done;
  logic       rd_load;
  logic       rd_done;
  logic [5:0] rd_raster;

  assign din_ready = ena & ~full[wr_bank];
  assign wr_acc    = din_valid & din_ready;

  // A start-of-block marker always restarts the block at scan position 0,
  // silently abandoning whatever partial block was in progress.
  assign wr_pos    = din_sof ? 6'd0 : wr_idx;
  assign wr_raster = ZZ2R[wr_pos];
  assign wr_done   = wr_acc & (wr_pos == 6'd63);

  // Load a new beat when the current one is absent or being consumed.
  assign rd_load   = ena & full[rd_bank] & (~dout_valid | dout_ready);
  assign rd_done   = rd_load & (rd_idx == 6'd63);

`ifdef JPEG_IZIGZAG_TRANSPOSE_EN
  // Column-major drain: swap the row and column fields of the read index.
  assign rd_raster = {rd_idx[2:0], rd_idx[5:3]};
`else
  assign rd_raster = rd_idx;
`endif

  // Coefficient store: write each accepted coefficient at its raster slot.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_bank, wr_raster}] <= din;
    end
  end

  // Write pointer: advance per accept, flip bank after scan position 63.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= 6'd0;
    end else if (wr_acc) begin
      wr_idx <= 6'(wr_pos + 6'd1);
      if (wr_pos == 6'd63) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Per-bank full flags: set by the writer on block completion, cleared by
  // the reader once raster 63 has been loaded. Writer and reader can only
  // touch the same edge on different banks (writer needs it empty, reader
  // needs it full), so the two conditions never collide on one flag.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      // Full flag for bank gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          full[gi] <= 1'b0;
        end else if (wr_done && (wr_bank == 1'(gi))) begin
          full[gi] <= 1'b1;
        end else if (rd_done && (rd_bank == 1'(gi))) begin
          full[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Output register and read pointer: registered read straight from the
  // store; the beat holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_idx   <= 6'd0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
      rd_bank    <= 1'b0;
      rd_idx     <= 6'd0;
    end else if (rd_load) begin
      dout       <= mem[{rd_bank, rd_raster}];
      dout_idx   <= rd_raster;
      dout_first <= (rd_idx == 6'd0);
      dout_last  <= (rd_idx == 6'd63);
      dout_valid <= 1'b1;
      rd_idx     <= 6'(rd_idx + 6'd1);
      if (rd_idx == 6'd63) begin
        rd_bank <= ~rd_bank;
      end
    end else if (ena && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_izigzag_buf.sv
// tb_jpeg_izigzag_buf: directed bench for the inverse zigzag buffer with an
// in-bench reference model (diagonal-walk zigzag order, expected-beat queue).
`timescale 1ns/1ps
module tb_jpeg_izigzag_buf;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_sof = 1'b0;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic [5:0]    dout_idx;
  logic          dout_first;
  logic          dout_last;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  jpeg_izigzag_buf #(.DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .din(din), .din_valid(din_valid), .din_sof(din_sof), .din_ready(din_ready),
    .dout(dout), .dout_idx(dout_idx), .dout_first(dout_first),
    .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] val;
    int            idx;
    bit            first;
    bit            last;
  } beat_t;

  beat_t         exp_q[$];
  int            zz2r_m[64];
  logic [DW-1:0] blk[64];
  int            m_widx = 0;
  logic [DW-1:0] seen_val[64];
  int            out_cnt = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_dout;
  logic [5:0]    prev_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Zigzag order built by walking anti-diagonals, alternating direction.
  initial begin
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz2r_m[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz2r_m[n] = r * 8 + (s - r); n++; end
      end
    end
  end

  // Reference model and compare process, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_widx = 0;
      prev_hold = 0;
    end else begin
      if (!ena) chk("ready_low_when_disabled", din_ready, 0);
      if (prev_hold) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout, prev_dout);
        chk("hold_idx", dout_idx, prev_idx);
      end
      chk("spurious_valid", dout_valid && (exp_q.size() == 0), 0);
      if (ena && dout_valid && dout_ready && exp_q.size() != 0) begin
        beat_t b;
        b = exp_q.pop_front();
        chk("dout", dout, b.val);
        chk("dout_idx", dout_idx, b.idx);
        chk("dout_first", dout_first, b.first);
        chk("dout_last", dout_last, b.last);
        seen_val[dout_idx] = dout;
        out_cnt++;
      end
      if (ena && din_valid && din_ready) begin
        int pos;
        pos = din_sof ? 0 : m_widx;
        blk[zz2r_m[pos]] = din;
        if (pos == 63) begin
          for (int k = 0; k < 64; k++) begin
            beat_t nb;
`ifdef JPEG_IZIGZAG_TRANSPOSE_EN
            nb.idx = (k % 8) * 8 + k / 8;
`else
            nb.idx = k;
`endif
            nb.val   = blk[nb.idx];
            nb.first = (k == 0);
            nb.last  = (k == 63);
            exp_q.push_back(nb);
          end
          m_widx = 0;
        end else begin
          m_widx = pos + 1;
        end
      end
      prev_hold = dout_valid && !(ena && dout_ready);
      prev_dout = dout;
      prev_idx  = dout_idx;
    end
  end

  task automatic send(input logic [DW-1:0] v, input bit sof, output int stalls);
    din = v; din_sof = sof; din_valid = 1'b1; stalls = 0;
    forever begin
      @(negedge clk);
      if (ena && din_ready) break;
      stalls++;
      if (stalls > 300) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0; din_sof = 1'b0;
  endtask

  task automatic send_block(input int base, input int step, input bit sof0, output int stalls);
    int s;
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      send(DW'(base + k * step), sof0 && (k == 0), s);
      stalls += s;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dout_valid) break;
      n++;
      if (n > 400) begin chk("drain_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, gaps, c0;
    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_idx", dout_idx, 0);
    chk("rst_first", dout_first, 0);
    chk("rst_last", dout_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_ena0", din_ready, 0);
    ena = 1'b1; #1;
    chk("ready_idle", din_ready, 1);
    $display("txn reset/idle done");

    // Single block, din = zigzag index
    dout_ready = 1'b1;
    send_block(0, 1, 1'b1, st);
    chk("single_stalls", st, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!dout_valid && n < 10);
    chk("latency", n, 2);
    wait_drain();
    chk("pin_r0", seen_val[0], 0);
    chk("pin_r1", seen_val[1], 1);
    chk("pin_r2", seen_val[2], 5);
    chk("pin_r3", seen_val[3], 6);
    chk("pin_r8", seen_val[8], 2);
    chk("pin_r9", seen_val[9], 4);
    chk("pin_r15", seen_val[15], 42);
    chk("pin_r63", seen_val[63], 63);
    $display("txn single block outputs=%0d", out_cnt);

    // Three back-to-back blocks, no bubbles
    gaps = 0;
    fork
      begin
        int s3, s;
        s3 = 0;
        for (int b = 0; b < 3; b++) begin
          send_block(100 + b * 500, 7, (b == 0), s);
          s3 += s;
        end
        chk("b2b_stalls", s3, 0);
      end
      begin
        int w;
        w = 0;
        do begin @(negedge clk); w++; end while (!dout_valid && w < 300);
        for (int i = 1; i < 192; i++) begin
          @(negedge clk);
          if (!dout_valid) gaps++;
        end
      end
    join
    chk("b2b_gaps", gaps, 0);
    wait_drain();
    $display("txn back-to-back outputs=%0d", out_cnt);

    // Backpressure: two blocks fill, third must wait
    dout_ready = 1'b0;
    send_block(3000, 3, 1'b1, st);
    send_block(50, 11, 1'b0, n);
    chk("bp_stalls_128", st + n, 0);
    din = 12'd777; din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_ready_low", din_ready, 0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (din_ready) break;
      n++;
      if (n > 200) begin chk("bp_resume_timeout", 0, 1); break; end
    end
    chk("bp_resume_valid", dout_valid, 1);
    chk("bp_resume_last", dout_last, 1);
    chk("bp_resume_idx", dout_idx, 63);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int k = 1; k < 64; k++) begin
      send(DW'(777 + k), 1'b0, st);
    end
    wait_drain();
    $display("txn backpressure outputs=%0d", out_cnt);

    // Resync: partial ramp abandoned at wr_idx=20
    c0 = out_cnt;
    for (int k = 0; k < 20; k++) send(DW'(1000 + k), (k == 0), st);
    send_block(2000, 1, 1'b1, st);
    wait_drain();
    chk("resync_count", out_cnt - c0, 64);
    chk("resync_r0", seen_val[0], 2000);
    chk("resync_r1", seen_val[1], 2001);
    chk("resync_r8", seen_val[8], 2002);
    chk("resync_r63", seen_val[63], 2063);
    $display("txn resync outputs=%0d", out_cnt);

    // ena low for 5 cycles while writing and draining
    fork
      begin
        int sa, sb;
        send_block(400, 5, 1'b1, sa);
        send_block(1500, 9, 1'b1, sb);
        chk("ena_stalls", sa + sb, 5);
      end
      begin
        int oc;
        repeat (80) @(posedge clk); #1;
        oc = out_cnt;
        ena = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("ena_frozen_outputs", out_cnt, oc);
        ena = 1'b1;
      end
    join
    wait_drain();
    $display("txn ena toggle outputs=%0d", out_cnt);

    // Asynchronous reset mid-drain
    send_block(600, 2, 1'b1, st);
    n = 0;
    c0 = out_cnt;
    while (out_cnt < c0 + 10 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    chk("pre_reset_valid", dout_valid, 1);
    rst_n = 1'b0; #1;
    chk("async_rst_valid", dout_valid, 0);
    chk("async_rst_idx", dout_idx, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("post_rst_ready", din_ready, 1);
    send_block(3500, 1, 1'b0, st);
    wait_drain();
    chk("post_rst_r2", seen_val[2], 3505);
    $display("txn reset mid-drain outputs=%0d", out_cnt);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
